// File: rtl/predict_update_ctrl_if.sv
// Bundle of signals between the predictor controller and its neighbours:
// fetch lookup, branch-resolution update, and the shared BHT/PHT table port.
// Handshake rules:
//   - lookup: lookup_req is a request; lookup_ack answers in the same cycle
//     and pred_taken is only meaningful while lookup_ack is high.
//   - update: an update transfers on a rising edge when upd_valid and
//     upd_ready are both high; upd_valid may rise without waiting for ready.
//   - tables: rdata is a combinational function of the index; a write with
//     we=1 lands on the rising edge and is visible the following cycle.
interface predict_update_ctrl_if;
    logic        flush_tables;
    logic        lookup_req;
    logic [15:0] lookup_pc;
    logic        lookup_ack;
    logic        pred_taken;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic        upd_ready;
    logic        busy;
    logic [2:0]  bht_ind;
    logic [3:0]  bht_rdata;
    logic        bht_we;
    logic [3:0]  bht_wdata;
    logic [6:0]  pht_ind;
    logic [1:0]  pht_rdata;
    logic        pht_we;
    logic [1:0]  pht_wdata;

    // Controller side.
    modport slave (
        input  flush_tables, lookup_req, lookup_pc,
        input  upd_valid, upd_pc, upd_taken,
        input  bht_rdata, pht_rdata,
        output lookup_ack, pred_taken, upd_ready, busy,
        output bht_ind, bht_we, bht_wdata,
        output pht_ind, pht_we, pht_wdata
    );

    // Environment side: fetch, branch resolution and the table storage.
    modport master (
        output flush_tables, lookup_req, lookup_pc,
        output upd_valid, upd_pc, upd_taken,
        output bht_rdata, pht_rdata,
        input  lookup_ack, pred_taken, upd_ready, busy,
        input  bht_ind, bht_we, bht_wdata,
        input  pht_ind, pht_we, pht_wdata
    );
endinterface

// File: rtl/predict_update_ctrl.sv
// Branch predictor table controller: initialises the 8x4 BHT and 128x2 PHT,
// queues resolved-branch updates, and arbitrates the single table port
// between fetch lookups and queued updates with a starvation guard.
module predict_update_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    predict_update_ctrl_if.slave               bus,
    output logic                               dbg_state_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    dbg_count_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       STARVE_MAX = 3'(STARVE_LIMIT);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [2:0]       starve_q, starve_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Each entry keeps only what the tables need: {pc[3:1], taken}.
    logic [3:0]       fifo_mem [FIFO_DEPTH];

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             upd_grant;
    logic             lk_grant;
    logic [3:0]       head;
    logic [2:0]       head_idx;
    logic             head_taken;
    logic [1:0]       pht_sat;

    // Only PC bits [3:1] address the tables.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc[15:4], bus.lookup_pc[0],
                              bus.upd_pc[15:4], bus.upd_pc[0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign head       = fifo_mem[rd_ptr_q];
    assign head_idx   = head[3:1];
    assign head_taken = head[0];

    // A flush discards any same-cycle push along with the queue contents.
    assign push = bus.upd_valid && !full && !bus.flush_tables;
    assign pop  = upd_grant;

    assign bus.upd_ready  = !full;
    assign bus.busy       = (state_q == ST_INIT);
    assign bus.lookup_ack = lk_grant;
    assign dbg_state_o    = state_q;
    assign dbg_count_o    = count_q;

    // Port arbitration: updates win when the queue is full, fetch is idle, or
    // fetch has been favoured STARVE_LIMIT times in a row. A flush cycle grants
    // nothing so no stale update can slip out ahead of the re-initialisation.
    always_comb begin
        upd_grant = 1'b0;
        lk_grant  = 1'b0;
        if (state_q == ST_RUN && !bus.flush_tables) begin
            if (!empty && (full || !bus.lookup_req || starve_q == STARVE_MAX)) begin
                upd_grant = 1'b1;
            end else if (bus.lookup_req) begin
                lk_grant = 1'b1;
            end
        end
    end

    // Two-bit saturating counter step for the PHT entry being updated.
    always_comb begin
        pht_sat = bus.pht_rdata;
        if (head_taken) begin
            if (bus.pht_rdata != 2'b11) pht_sat = bus.pht_rdata + 2'b01;
        end else begin
            if (bus.pht_rdata != 2'b00) pht_sat = bus.pht_rdata - 2'b01;
        end
    end

    // Table port drive: sweep writes in INIT, otherwise whichever side won.
    always_comb begin
        bus.bht_ind    = 3'd0;
        bus.bht_we     = 1'b0;
        bus.bht_wdata  = 4'd0;
        bus.pht_ind    = 7'd0;
        bus.pht_we     = 1'b0;
        bus.pht_wdata  = 2'b00;
        bus.pred_taken = 1'b0;
        if (state_q == ST_INIT) begin
            // Write enables are gated by rst_n so nothing is written in reset.
            bus.bht_ind   = cnt_q[2:0];
            bus.bht_we    = rst_n;
            bus.pht_ind   = cnt_q;
            bus.pht_we    = rst_n;
            bus.pht_wdata = 2'b01;
        end else if (upd_grant) begin
            bus.bht_ind   = head_idx;
            bus.pht_ind   = {head_idx, bus.bht_rdata};
            bus.bht_we    = 1'b1;
            bus.pht_we    = 1'b1;
            bus.bht_wdata = {bus.bht_rdata[2:0], head_taken};
            bus.pht_wdata = pht_sat;
        end else if (lk_grant) begin
            bus.bht_ind    = bus.lookup_pc[3:1];
            bus.pht_ind    = {bus.lookup_pc[3:1], bus.bht_rdata};
            bus.pred_taken = bus.pht_rdata[1];
        end
    end

    // Next state: sweep counter walks 0..127 in INIT; flush restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush_tables) begin
            state_d = ST_INIT;
            cnt_d   = 7'd0;
        end else if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'd127) state_d = ST_RUN;
        end
    end

    // Next queue pointers, occupancy and starvation count.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;

        starve_d = starve_q;
        if (pop || empty)                        starve_d = 3'd0;
        else if (lk_grant && starve_q != 3'b111) starve_d = starve_q + 3'd1;

        if (bus.flush_tables) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            starve_d = 3'd0;
        end
    end

    // State, sweep counter and queue bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= 7'd0;
            starve_q <= 3'd0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {bus.upd_pc[3:1], bus.upd_taken};
    end

endmodule

// File: tb/tb_predict_update_ctrl.sv
// Directed bench for predict_update_ctrl with behavioural BHT/PHT storage.
module tb_predict_update_ctrl;

  logic       clk;
  logic       rst_n;
  logic       dbg_state;
  logic [2:0] dbg_count;

  predict_update_ctrl_if bus ();

  predict_update_ctrl #(.FIFO_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_count_o (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- table storage model ----------------
  logic [3:0] bht_mem [8];
  logic [1:0] pht_mem [128];

  assign bus.bht_rdata = bht_mem[bus.bht_ind];
  assign bus.pht_rdata = pht_mem[bus.pht_ind];

  always @(posedge clk) begin
    if (bus.bht_we) bht_mem[bus.bht_ind] <= bus.bht_wdata;
    if (bus.pht_we) pht_mem[bus.pht_ind] <= bus.pht_wdata;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q [$];     // {bht_we, pht_we, bht_ind, pht_ind, pht_wdata, bht_wdata}
  logic [7:0]  exp_lk_q [$];  // {pht_ind, pred_taken}
  logic        lk_chk;
  logic [17:0] act_w;
  logic [17:0] exp_w;
  logic [7:0]  exp_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT writes the tables in RUN
  // or answers a lookup the stimulus marked for checking.
  always @(negedge clk) begin
    if (rst_n && !bus.busy) begin
      if (bus.bht_we || bus.pht_we) begin
        act_w = {bus.bht_we, bus.pht_we, bus.bht_ind, bus.pht_ind, bus.pht_wdata, bus.bht_wdata};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL upd_write: got unexpected write %0h expected none (t=%0t)", act_w, $time);
        end else begin
          exp_w = exp_q.pop_front();
          chk("upd_write", 32'(act_w), 32'(exp_w));
        end
      end
      if (lk_chk) begin
        chk("lookup_ack", 32'(bus.lookup_ack), 32'd1);
        if (bus.lookup_ack && exp_lk_q.size() != 0) begin
          exp_l = exp_lk_q.pop_front();
          chk("lookup_pred", 32'({bus.pht_ind, bus.pred_taken}), 32'(exp_l));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks n sweep cycles starting at the current cnt=0 cycle; optionally
  // checks the first RUN cycle afterwards (busy low, no writes).
  task automatic sweep_check(input int n, input bit expect_run);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("sweep",
          32'({bus.busy, bus.pht_we, bus.bht_we, bus.pht_ind, bus.bht_ind,
               bus.pht_wdata, bus.bht_wdata, dbg_count}),
          32'({1'b1, 1'b1, 1'b1, 7'(i), 3'(i), 2'b01, 4'b0000, 3'd0}));
      tick();
    end
    if (expect_run) begin
      @(negedge clk);
      chk("run_entry", 32'({bus.busy, bus.pht_we, bus.bht_we}), 32'd0);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [17:0] sat_exp [7];
  logic [17:0] full_exp [5];
  logic [15:0] full_pc [5];
  logic        full_tk [5];
  logic [2:0]  full_cnt [6];
  logic [8:0]  starve_pat;
  logic [5:0]  full_pat;
  logic        acc;
  int          k;

  initial begin
    sat_exp[0] = {2'b11, 3'd0, 7'h00, 2'b10, 4'b0001};
    sat_exp[1] = {2'b11, 3'd0, 7'h01, 2'b10, 4'b0011};
    sat_exp[2] = {2'b11, 3'd0, 7'h03, 2'b10, 4'b0111};
    sat_exp[3] = {2'b11, 3'd0, 7'h07, 2'b10, 4'b1111};
    sat_exp[4] = {2'b11, 3'd0, 7'h0F, 2'b10, 4'b1111};
    sat_exp[5] = {2'b11, 3'd0, 7'h0F, 2'b11, 4'b1111};
    sat_exp[6] = {2'b11, 3'd0, 7'h0F, 2'b11, 4'b1111};

    full_pc[0] = 16'h0004; full_tk[0] = 1'b1; full_exp[0] = {2'b11, 3'd2, 7'h20, 2'b10, 4'b0001};
    full_pc[1] = 16'h0008; full_tk[1] = 1'b0; full_exp[1] = {2'b11, 3'd4, 7'h40, 2'b00, 4'b0000};
    full_pc[2] = 16'h000A; full_tk[2] = 1'b1; full_exp[2] = {2'b11, 3'd5, 7'h50, 2'b10, 4'b0001};
    full_pc[3] = 16'h000C; full_tk[3] = 1'b1; full_exp[3] = {2'b11, 3'd6, 7'h60, 2'b10, 4'b0001};
    full_pc[4] = 16'h000E; full_tk[4] = 1'b0; full_exp[4] = {2'b11, 3'd7, 7'h70, 2'b00, 4'b0000};
    full_cnt[0] = 3'd0; full_cnt[1] = 3'd1; full_cnt[2] = 3'd2;
    full_cnt[3] = 3'd3; full_cnt[4] = 3'd4; full_cnt[5] = 3'd3;
    starve_pat = 9'b111011111;   // lookup_ack per cycle, bit 0 = push cycle
    full_pat   = 6'b101111;      // upd_ready and lookup_ack per cycle

    rst_n            = 1'b0;
    lk_chk           = 1'b0;
    bus.flush_tables = 1'b0;
    bus.lookup_req   = 1'b1;
    bus.lookup_pc    = 16'h0000;
    bus.upd_valid    = 1'b0;
    bus.upd_pc       = 16'h0000;
    bus.upd_taken    = 1'b0;

    // Reset values, with a lookup request present to prove it is refused.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd1);
    chk("rst_ready", 32'(bus.upd_ready), 32'd1);
    chk("rst_ack",   32'(bus.lookup_ack), 32'd0);
    chk("rst_we",    32'({bus.bht_we, bus.pht_we}), 32'd0);
    chk("rst_state", 32'({dbg_state, dbg_count}), 32'd0);
    tick();
    bus.lookup_req = 1'b0;
    rst_n = 1'b1;

    // Full initialisation sweep after reset release.
    sweep_check(128, 1'b1);

    // Single update then lookup of the same PC.
    tick();
    bus.upd_valid = 1'b1; bus.upd_pc = 16'h0006; bus.upd_taken = 1'b1;
    exp_q.push_back({2'b11, 3'd3, 7'h30, 2'b10, 4'b0001});
    tick();
    bus.upd_valid = 1'b0;
    tick();
    bus.lookup_req = 1'b1; bus.lookup_pc = 16'h0006; lk_chk = 1'b1;
    exp_lk_q.push_back({7'h31, 1'b0});
    tick();
    bus.lookup_req = 1'b0; lk_chk = 1'b0;

    // Saturation: seven taken updates at pc 0, then a lookup.
    for (int j = 0; j < 7; j++) begin
      bus.upd_valid = 1'b1; bus.upd_pc = 16'h0000; bus.upd_taken = 1'b1;
      exp_q.push_back(sat_exp[j]);
      tick();
    end
    bus.upd_valid = 1'b0;
    tick();
    tick();
    bus.lookup_req = 1'b1; bus.lookup_pc = 16'h0000; lk_chk = 1'b1;
    exp_lk_q.push_back({7'h0F, 1'b1});
    tick();
    bus.lookup_req = 1'b0; lk_chk = 1'b0;
    drain("sat_drain");

    // Starvation guard with lookup_req held high.
    tick();
    bus.lookup_req = 1'b1; bus.lookup_pc = 16'h0006;
    bus.upd_valid = 1'b1; bus.upd_pc = 16'h0002; bus.upd_taken = 1'b0;
    exp_q.push_back({2'b11, 3'd1, 7'h10, 2'b00, 4'b0000});
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("starve_ack", 32'(bus.lookup_ack), 32'(starve_pat[i]));
      chk("starve_we", 32'({bus.bht_we, bus.pht_we}), starve_pat[i] ? 32'd0 : 32'd3);
      tick();
      bus.upd_valid = 1'b0;
    end

    // Full FIFO: five back-to-back pushes under continuous lookups.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 5) begin
        bus.upd_valid = 1'b1; bus.upd_pc = full_pc[k]; bus.upd_taken = full_tk[k];
      end else begin
        bus.upd_valid = 1'b0;
      end
      @(negedge clk);
      chk("full_ready", 32'(bus.upd_ready), 32'(full_pat[c]));
      chk("full_ack",   32'(bus.lookup_ack), 32'(full_pat[c]));
      chk("full_count", 32'(dbg_count), 32'(full_cnt[c]));
      acc = bus.upd_valid && bus.upd_ready;
      tick();
      if (acc) begin
        exp_q.push_back(full_exp[k]);
        k++;
      end
    end
    chk("full_accepted", 32'(k), 32'd5);
    bus.upd_valid = 1'b0;
    bus.lookup_req = 1'b0;
    drain("full_drain");

    // Flush with three queued entries; none of them may ever be written.
    bus.lookup_req = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.upd_valid = 1'b1; bus.upd_pc = 16'h000C; bus.upd_taken = 1'b1;
      tick();
    end
    bus.flush_tables = 1'b1;
    bus.lookup_req = 1'b0;
    @(negedge clk);
    chk("flush_pre_count", 32'(dbg_count), 32'd3);
    chk("flush_cycle_we", 32'({bus.bht_we, bus.pht_we}), 32'd0);
    tick();
    bus.flush_tables = 1'b0;
    bus.upd_valid = 1'b0;
    sweep_check(128, 1'b1);
    repeat (4) tick();

    // Reset mid-sweep at cnt=50 restarts the sweep from 0.
    bus.flush_tables = 1'b1;
    tick();
    bus.flush_tables = 1'b0;
    sweep_check(50, 1'b0);
    @(negedge clk);
    chk("pre_rst_cnt", 32'(bus.pht_ind), 32'd50);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'({bus.bht_we, bus.pht_we}), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    sweep_check(128, 1'b1);

    // Tables really were re-initialised: pc 0 history back to zero.
    tick();
    bus.lookup_req = 1'b1; bus.lookup_pc = 16'h0000; lk_chk = 1'b1;
    exp_lk_q.push_back({7'h00, 1'b0});
    tick();
    bus.lookup_req = 1'b0; lk_chk = 1'b0;
    tick();

    chk("exp_upd_empty", 32'(exp_q.size()), 32'd0);
    chk("exp_lk_empty", 32'(exp_lk_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/predict_update_ctrl.md
# predict_update_ctrl

Sequencing and arbitration controller for the branch predictor's single-ported tables: the 8-entry × 4-bit branch history table (BHT) and the 128-entry × 2-bit pattern history table (PHT). It initializes both tables after reset or flush, and queues resolved-branch updates in a small FIFO. Each cycle it grants the shared table port either to a fetch-stage lookup or to one queued update, with a starvation guard so updates are never locked out. It sits between fetch and branch resolution on one side and the predictor tables on the other.

## Interface
- `FIFO_DEPTH`, default 4: resolved-branch update queue depth.
- `STARVE_LIMIT`, default 4: consecutive lookup grants with a non-empty FIFO before an update is forced.
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `flush_tables`, in, 1: synchronous pulse; restarts initialization.
- `lookup_req`, in, 1: fetch requests a prediction.
- `lookup_pc`, in, 16: fetch PC; only bits [3:1] are used.
- `lookup_ack`, out, 1: the lookup is granted this cycle (combinational).
- `pred_taken`, out, 1: prediction; valid only when `lookup_ack`=1.
- `upd_valid`, in, 1: a resolved branch is presented.
- `upd_pc`, in, 16: PC of the resolved branch.
- `upd_taken`, in, 1: resolved direction.
- `upd_ready`, out, 1: the FIFO can accept an update; a push occurs when `upd_valid` & `upd_ready`.
- `busy`, out, 1: initialization sweep in progress.
- `bht_ind`, out, 3: BHT index.
- `bht_rdata`, in, 4: BHT combinational read data.
- `bht_we`, out, 1: BHT write enable.
- `bht_wdata`, out, 4: BHT write data.
- `pht_ind`, out, 7: PHT index.
- `pht_rdata`, in, 2: PHT combinational read data.
- `pht_we`, out, 1: PHT write enable.
- `pht_wdata`, out, 2: PHT write data.

## Operation
- Two states: INIT and RUN. Reset and `flush_tables` both enter INIT.
- **INIT state**
  - A 7-bit sweep counter runs 0 to 127.
  - `pht_ind`=cnt, `pht_we`=1, `pht_wdata`=2'b01 (weakly not-taken).
  - `bht_ind`=cnt[2:0], `bht_we`=1, `bht_wdata`=0.
  - `busy`=1 and `lookup_ack`=0. No FIFO pops occur.
  - After the write at cnt=127, the state moves to RUN.
- **Flush behaviour**
  - `flush_tables` in any state clears the FIFO and the starvation counter, and sets the sweep counter to 0.
  - A push in the same cycle as `flush_tables` is discarded.
- **Pushes**
  - Pushes are accepted in both INIT and RUN whenever the FIFO is not full.
  - `upd_ready` = !full. There is no bypass: a pushed entry is poppable no earlier than the next cycle.
- **RUN arbitration (per cycle)**
  - An update is granted if the FIFO is non-empty and any of the following holds: the FIFO is full, `lookup_req`=0, or starve_cnt == `STARVE_LIMIT`.
  - Otherwise a requesting lookup is granted.
- **Lookup grant**
  - `bht_ind`=`lookup_pc`[3:1].
  - `pht_ind`={`lookup_pc`[3:1], `bht_rdata`}.
  - `pred_taken`=`pht_rdata`[1]. No writes occur.
- **Update grant** (FIFO head is popped)
  - `bht_ind`=pc[3:1]; `pht_ind`={pc[3:1], `bht_rdata`}. The history used is the BHT value at update time.
  - `pht_wdata` is the 2-bit saturating counter: taken increments to a maximum of 11; not-taken decrements to a minimum of 00.
  - `bht_wdata`={`bht_rdata`[2:0], taken}.
  - `bht_we`=`pht_we`=1.
- **Starvation counter** (3 bits)
  - Increments on each lookup grant while the FIFO is non-empty.
  - Clears on any pop, or whenever the FIFO is empty.
- **FIFO**
  - Circular buffer with wrapping read and write pointers and an occupancy count of 0 to `FIFO_DEPTH`.
  - Push and pop in the same cycle leave the count unchanged.

## Timing
- **Reset values:** state INIT, cnt 0, FIFO empty, starve_cnt 0. Outputs: `busy`=1, `upd_ready`=1, `lookup_ack`=0. Both write enables are forced to 0 while `rst_n`=0.
- **Initialization** occupies exactly 128 cycles after reset release, or after the cycle following a `flush_tables` pulse. The first RUN cycle is cycle 129.
- **Mid-sweep reset:** asserting `rst_n` low mid-sweep aborts immediately; the sweep restarts from 0 on release.
- **Lookup:** zero-cycle latency (Mealy). `lookup_ack` and `pred_taken` are valid in the same cycle as `lookup_req`.
- **Update visibility:** a table write becomes visible to a lookup in the following cycle.
- **Worst-case update wait:** with `lookup_req` held high, a queued update is written within `STARVE_LIMIT`+1 cycles of becoming poppable.

## Test plan
- **Reset release, no traffic:** `busy`=1 for 128 cycles. `pht_ind` steps 0 to 127 with `pht_wdata`=01 and `bht_wdata`=0. Cycle 129: `busy`=0, both write enables 0.
- **Single update, then lookup:** push `upd_pc`=0x0006, taken=1, into initialized tables. The next cycle shows `bht_ind`=3, `pht_ind`=0x30, `pht_wdata`=10, `bht_wdata`=0001. A later lookup of 0x0006 shows `pht_ind`=0x31 and `pred_taken`=0.
- **Saturation:** six taken updates at pc 0x0000 write entries 0x00, 0x01, 0x03, 0x07 (each to 10), then 0x0F twice (10, then 11). A seventh taken update writes 0x0F with `pht_wdata`=11. A lookup of 0x0000 then gives `pred_taken`=1.
- **Starvation:** hold `lookup_req`=1 and push one update. Expect `lookup_ack`=1 for 4 cycles, then 0 for one cycle with both write enables high, then 1 continuously.
- **Full FIFO:** hold `lookup_req`=1 and push on 5 consecutive cycles. `upd_ready`=0 in the cycle the count reaches 4, and the update is granted that cycle. The fifth push waits and is accepted the next cycle. The count never exceeds 4.
- **Flush mid-operation:** with 3 entries queued, pulse `flush_tables`. Expect the FIFO empty, `busy`=1 for 128 cycles, and no update writes outside the sweep. Asserting `rst_n` low at sweep cnt=50 restarts the sweep at 0.
